// File: rtl/xy_out_port_arbiter_pkg.sv
// Shared NoC definitions: router port indices, port count and output-arbiter FSM states.
package xy_out_port_arbiter_pkg;

    localparam int N_PORTS = 5;

    typedef enum logic [2:0] {
        HOME  = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xy_out_port_arbiter_picker.sv
// Combinational round-robin picker: first requester found scanning from ptr+1 (mod N), wrapping back to ptr.
module rr_priority_picker #(
    parameter  int N  = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          vld
);

    int idx;

    always_comb begin
        pick = '0;
        vld  = 1'b0;
        idx  = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!vld && req[idx]) begin
                pick[idx] = 1'b1;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xy_out_port_arbiter.sv
// Packet-locking round-robin arbiter for one XY router output with a beat-count watchdog.
module xy_out_port_arbiter #(
    parameter  int N_PORTS   = xy_out_port_arbiter_pkg::N_PORTS,
    parameter  int MAX_BEATS = 256,
    localparam int IW        = $clog2(N_PORTS),
    localparam int CW        = $clog2(MAX_BEATS) + 1
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    input  logic [N_PORTS-1:0] req_i,
    input  logic [N_PORTS-1:0] last_i,
    input  logic               out_tready_i,
    output logic [N_PORTS-1:0] grant_o,
    output logic [IW-1:0]      grant_idx_o,
    output logic               busy_o,
    output logic               err_o
);

    import xy_out_port_arbiter_pkg::*;

    arb_state_e         state, state_nxt;
    logic [N_PORTS-1:0] grant_nxt;
    logic [IW-1:0]      idx_nxt, ptr, ptr_nxt, pick_idx;
    logic [CW-1:0]      cnt, cnt_nxt, cnt_inc;
    logic               busy_nxt, err_nxt;
    logic [N_PORTS-1:0] pick;
    logic               pick_vld;
    logic               beat, last_beat;

    rr_priority_picker #(.N(N_PORTS)) u_picker (
        .req  (req_i),
        .ptr  (ptr),
        .pick (pick),
        .vld  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_PORTS; i++)
            if (pick[i]) pick_idx = IW'(i);
    end

    // grant_o is one-hot, so masking selects the granted port's TVALID/TLAST
    assign beat      = (|(req_i & grant_o)) & out_tready_i;
    assign last_beat = |(last_i & grant_o);
    assign cnt_inc   = cnt + 1'b1;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_o;
        idx_nxt   = grant_idx_o;
        busy_nxt  = busy_o;
        err_nxt   = err_o;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_nxt = ST_LOCKED;
                    grant_nxt = pick;
                    idx_nxt   = pick_idx;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (beat) begin
                    cnt_nxt = cnt_inc;
                    // a last beat landing on the limit is a clean release, not an error
                    if (last_beat || cnt_inc == CW'(MAX_BEATS)) begin
                        state_nxt = ST_IDLE;
                        grant_nxt = '0;
                        idx_nxt   = '0;
                        busy_nxt  = 1'b0;
                        ptr_nxt   = grant_idx_o;
                        err_nxt   = err_o | ~last_beat;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant_o     <= '0;
            grant_idx_o <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            ptr         <= IW'(N_PORTS - 1);
            cnt         <= '0;
        end else begin
            grant_o     <= grant_nxt;
            grant_idx_o <= idx_nxt;
            busy_o      <= busy_nxt;
            err_o       <= err_nxt;
            ptr         <= ptr_nxt;
            cnt         <= cnt_nxt;
        end
    end

endmodule

// File: doc/xy_out_port_arbiter.md
XY_OUT_PORT_ARBITER -- requirements
Module: xy_out_port_arbiter

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 5, giving the number of router inputs competing for one output (HOME, NORTH, EAST, SOUTH, WEST).
REQ-002 The block SHALL have parameter MAX_BEATS, default 256, giving the watchdog limit on beats per packet.
REQ-003 The block SHALL have port ACLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port ARESETn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port req_i, input, N_PORTS bits: per-input TVALID of a flit routed to this output.
REQ-006 The block SHALL have port last_i, input, N_PORTS bits: per-input TLAST.
REQ-007 The block SHALL have port out_tready_i, input, 1 bit: downstream TREADY of this output.
REQ-008 The block SHALL have port grant_o, output, N_PORTS bits: one-hot grant, driving the output mux select and the granted input's TREADY.
REQ-009 The block SHALL have port grant_idx_o, output, $clog2(N_PORTS) bits: binary index of the granted input.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while a packet is locked.
REQ-011 The block SHALL have port err_o, output, 1 bit: sticky watchdog error flag.

Function
REQ-012 The FSM SHALL have two states, IDLE and LOCKED.
REQ-013 In IDLE, when req_i is nonzero, the block SHALL select the first requester scanning round-robin from index ptr+1 (mod N_PORTS), register that grant, and enter LOCKED on the next edge; grant latency is 1 cycle.
REQ-014 In IDLE, grant_o SHALL be 0 and busy_o SHALL be 0.
REQ-015 In LOCKED, grant_o SHALL hold its value for the whole packet regardless of req_i; a deasserted req_i on the granted port is a legal gap and does not release the grant.
REQ-016 A beat SHALL be counted when req_i[g] and out_tready_i are both high, where g is the granted index.
REQ-017 The beat counter SHALL be $clog2(MAX_BEATS)+1 bits wide and SHALL be cleared on entry to LOCKED.
REQ-018 A beat with last_i[g] high SHALL release the grant: the next state is IDLE and ptr <= g.
REQ-019 Arbitration after a release SHALL occur in the following IDLE cycle, giving exactly one bubble cycle between packets.
REQ-020 If the beat counter reaches MAX_BEATS without a last beat, the block SHALL set err_o, force IDLE and set ptr <= g; err_o stays set until reset.
REQ-021 A last beat on the same cycle as the watchdog limit SHALL be treated as a normal release; err_o SHALL NOT be set.
REQ-022 Requests and last_i on non-granted ports SHALL be ignored.
REQ-023 grant_idx_o SHALL equal the encoded grant_o while in LOCKED and 0 while in IDLE.

Reset
REQ-024 Reset SHALL asynchronously force state=IDLE, grant_o=0, grant_idx_o=0, busy_o=0, err_o=0, beat counter=0 and ptr=N_PORTS-1, so that port 0 has first priority.
REQ-025 Reset asserted mid-packet SHALL drop the grant immediately, with no completion of the packet.

Structure
REQ-026 The port index enum (HOME=0, NORTH, EAST, SOUTH, WEST) and N_PORTS SHALL live in the shared NoC package, not be redefined locally.
REQ-027 The round-robin selection SHALL be a combinational sub-module rr_priority_picker (inputs: request vector and pointer; outputs: one-hot pick and valid).
REQ-028 All outputs SHALL be driven from registers.

Verification
REQ-029 Scenario: reset, then req_i=5'b00001 with a 3-beat packet and out_tready_i=1 -> grant_o=00001 one cycle after the request, busy_o high for 3 cycles, IDLE afterwards, ptr=0.
REQ-030 Scenario: all 5 ports request continuously with 1-beat packets -> grant order 0,1,2,3,4,0 with one bubble cycle between grants.
REQ-031 Scenario: granted port 2 drops req_i for 4 cycles mid-packet while port 3 requests -> grant_o stays 00100 until port 2's last beat.
REQ-032 Scenario: out_tready_i=0 while req_i[g]=1 and last_i[g]=1 -> no release; release occurs on the first cycle with out_tready_i=1.
REQ-033 Scenario: MAX_BEATS=4 and a packet without TLAST -> err_o=1 after the 4th beat, grant is released, and the next requester is granted.
REQ-034 Scenario: ARESETn pulsed low mid-packet on port 4 -> grant_o=0 asynchronously; after reset, simultaneous requests on ports 4 and 0 grant port 0.
